mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: AW, 12, address width in bits.
REQ-002 Parameter: DW, 16, data width in bits.
REQ-003 The block SHALL use one clock, and its reset SHALL be asynchronous and active-low.
REQ-004 Port list, clock and reset first:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- cpu_req  in  1  processor access request (MEMrq)
- cpu_rnw  in  1  processor read=1/write=0 (RnW)
- cpu_addr  in  AW  processor address
- cpu_wdata  in  DW  processor write data
- cpu_rdata  out  DW  processor read data
- cpu_ack  out  1  processor access-complete pulse
- ldr_req  in  1  loader/debug access request
- ldr_rnw  in  1  loader read=1/write=0
- ldr_addr  in  AW  loader address
- ldr_wdata  in  DW  loader write data
- ldr_rdata  out  DW  loader read data
- ldr_ack  out  1  loader access-complete pulse
- ldr_lock  in  1  locks memory to the loader; the processor is never granted while high
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid the cycle after mem_en
- cpu_stall  out  1  high while cpu_req is pending and not yet acked

Function
REQ-005 The FSM SHALL have three states: IDLE, ISSUE, RESP.
REQ-006 In IDLE or RESP, arbitration SHALL be evaluated every cycle, and the FSM SHALL go to ISSUE next if any eligible request exists, else to IDLE.
REQ-007 Eligible requests:
- ldr_req is always eligible.
- cpu_req is eligible only when ldr_lock=0.
REQ-008 Arbitration rules:
- Single eligible requester: that requester SHALL be granted.
- Both eligible: the requester not granted last SHALL win (round-robin via last_gnt register).
REQ-009 At the grant edge, the winner's rnw, addr and wdata SHALL be latched and last_gnt SHALL be updated.
REQ-010 In ISSUE, the block SHALL drive:
- mem_en=1
- mem_we = ~latched rnw
- mem_addr and mem_wdata from the latch
- then go to RESP.
REQ-011 In RESP:
- mem_en=0.
- Exactly one ack (cpu_ack or ldr_ack) SHALL pulse high for one cycle, for the granted requester.
- For a read, the matching rdata output SHALL register mem_rdata and hold it until that requester's next read completes.
REQ-012 Latency SHALL be fixed: grant edge -> ISSUE (1 cycle) -> RESP with ack (1 cycle); peak throughput SHALL be one access per 2 cycles.
REQ-013 A requester SHALL hold req, rnw, addr and wdata stable until ack; the block SHALL honour the latched values even if req drops after grant.
REQ-014 A requester that keeps req high in its ack cycle SHALL be treated as making a new request and SHALL be re-arbitrated that same cycle.
REQ-015 ldr_lock rising while a processor access is in ISSUE or RESP SHALL NOT abort that access; it SHALL only block subsequent processor grants.
REQ-016 cpu_stall SHALL equal cpu_req & ~cpu_ack, combinationally.
REQ-017 mem_we, mem_addr and mem_wdata SHALL be 0 whenever mem_en=0.
REQ-018 rdata outputs SHALL NOT change on write accesses or on the other requester's reads.

Reset
REQ-019 On rst_n low, the following SHALL apply immediately:
- state=IDLE
- last_gnt=LDR, so the processor wins the first tie
- mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0
- cpu_rdata=0, ldr_rdata=0
- cpu_ack=0, ldr_ack=0
REQ-020 Reset asserted in ISSUE or RESP SHALL abort the access with no ack; after release, the FSM SHALL re-arbitrate from IDLE.
REQ-021 The first grant SHALL occur no earlier than the first rising edge after rst_n deasserts.

Verification
REQ-022 Directed scenarios the bench SHALL cover:
- Processor read alone: cpu_req=1, rnw=1, addr=0x005, mem returns 0x1234 -> mem_en high at cycle 1, cpu_ack at cycle 2, cpu_rdata=0x1234, cpu_stall low after ack.
- Simultaneous requests from reset, both held: grant order CPU, LDR, CPU, LDR; acks alternate every 2 cycles.
- ldr_lock=1 with both requesting: only ldr_ack pulses and cpu_stall stays high; releasing the lock -> CPU granted on the next arbitration.
- Loader write: addr=0x0FF, wdata=0xBEEF -> mem_en=1, mem_we=1, mem_addr=0x0FF, mem_wdata=0xBEEF for one cycle; ldr_ack next cycle; ldr_rdata unchanged.
- rst_n pulsed low during ISSUE of a processor read -> no cpu_ack, all outputs 0; after release with cpu_req still high -> access reissued and acked 2 cycles after grant.
- cpu_req dropped the cycle after grant -> access completes with latched address and cpu_ack still pulses; no further grant follows.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: processor and loader share one synchronous memory.
// Round-robin between the two, with a loader lock that blocks processor grants.
module mem_arbiter #(
    parameter int unsigned AW = 12,
    parameter int unsigned DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cpu_req,
    input  logic          cpu_rnw,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_ack,
    input  logic          ldr_req,
    input  logic          ldr_rnw,
    input  logic [AW-1:0] ldr_addr,
    input  logic [DW-1:0] ldr_wdata,
    output logic [DW-1:0] ldr_rdata,
    output logic          ldr_ack,
    input  logic          ldr_lock,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          cpu_stall
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    typedef enum logic {
        GNT_CPU = 1'b0,
        GNT_LDR = 1'b1
    } gnt_t;

    state_t        state_q;
    gnt_t          last_gnt_q;
    logic          rnw_q;
    logic          mem_en_q;
    logic          mem_we_q;
    logic [AW-1:0] mem_addr_q;
    logic [DW-1:0] mem_wdata_q;
    logic [DW-1:0] cpu_rdata_q;
    logic [DW-1:0] ldr_rdata_q;
    logic          cpu_ack_q;
    logic          ldr_ack_q;

    logic          cpu_elig_c;
    logic          any_req_c;
    gnt_t          win_c;
    logic          win_rnw_c;
    logic [AW-1:0] win_addr_c;
    logic [DW-1:0] win_wdata_c;

    // Arbitration: the loader wins when alone or when the processor was granted last.
    always_comb begin
        cpu_elig_c  = cpu_req & ~ldr_lock;
        any_req_c   = cpu_elig_c | ldr_req;
        win_c       = GNT_CPU;
        win_rnw_c   = cpu_rnw;
        win_addr_c  = cpu_addr;
        win_wdata_c = cpu_wdata;
        if (ldr_req && (!cpu_elig_c || last_gnt_q == GNT_CPU)) begin
            win_c       = GNT_LDR;
            win_rnw_c   = ldr_rnw;
            win_addr_c  = ldr_addr;
            win_wdata_c = ldr_wdata;
        end
    end

    // Access sequencer; the memory bus registers double as the request latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            last_gnt_q  <= GNT_LDR;
            rnw_q       <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_rdata_q <= '0;
            ldr_rdata_q <= '0;
            cpu_ack_q   <= 1'b0;
            ldr_ack_q   <= 1'b0;
        end else begin
            cpu_ack_q   <= 1'b0;
            ldr_ack_q   <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            case (state_q)
                ISSUE: begin
                    state_q <= RESP;
                    if (last_gnt_q == GNT_LDR) begin
                        ldr_ack_q <= 1'b1;
                    end else begin
                        cpu_ack_q <= 1'b1;
                    end
                end
                default: begin
                    // Read data is on mem_rdata during RESP; capture it as we leave.
                    if (state_q == RESP && rnw_q) begin
                        if (last_gnt_q == GNT_LDR) begin
                            ldr_rdata_q <= mem_rdata;
                        end else begin
                            cpu_rdata_q <= mem_rdata;
                        end
                    end
                    if (any_req_c) begin
                        state_q     <= ISSUE;
                        last_gnt_q  <= win_c;
                        rnw_q       <= win_rnw_c;
                        mem_en_q    <= 1'b1;
                        mem_we_q    <= ~win_rnw_c;
                        mem_addr_q  <= win_addr_c;
                        mem_wdata_q <= win_wdata_c;
                    end else begin
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_rdata = cpu_rdata_q;
    assign ldr_rdata = ldr_rdata_q;
    assign cpu_ack   = cpu_ack_q;
    assign ldr_ack   = ldr_ack_q;
    assign cpu_stall = cpu_req & ~cpu_ack_q;

endmodule
